// File: rtl/data_sync_pkg.sv
// Constants shared by the data_sync CDC receiver and its sub-blocks.
package data_sync_pkg;

  localparam int DATA_SYNC_MIN_STAGES = 1;
  localparam int DATA_SYNC_MAX_STAGES = 5;

endpackage

// File: rtl/data_sync_sync_chain.sv
// Generic multi-flop synchronizer chain with asynchronous active-low reset.
// Each stage lives in its own generate block so every flop has exactly one driver.
module sync_chain #(
  parameter int WIDTH      = 1,
  parameter int NUM_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_reg;
      logic [WIDTH-1:0] stage_next;

      if (gi == 0) begin : g_head
        assign stage_next = async_in;
      end else begin : g_tail
        assign stage_next = g_stage[gi-1].stage_reg;
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= stage_next;
        end
      end
    end
  endgenerate

  assign sync_out = g_stage[NUM_STAGES-1].stage_reg;

endmodule

// File: rtl/data_sync.sv
// Destination-domain receiver: synchronizes the bus qualifier, edge-detects it,
// and captures the quasi-static bus on the resulting one-cycle pulse.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
);

  generate
    if (NUM_STAGES < DATA_SYNC_MIN_STAGES || NUM_STAGES > DATA_SYNC_MAX_STAGES) begin : g_bad_stages
      $error("data_sync: NUM_STAGES out of range");
    end
  endgenerate

  logic                 en_s;
  logic                 pg_reg;
  logic                 pulse_c;
  logic                 enable_pulse_reg;
  logic [BUS_WIDTH-1:0] sync_bus_reg;
  logic [BUS_WIDTH-1:0] sync_bus_next;

  // Only the qualifier is synchronized; the bus is held stable by the source.
  sync_chain #(
    .WIDTH      (1),
    .NUM_STAGES (NUM_STAGES)
  ) u_en_sync (
    .CLK      (CLK),
    .RST      (RST),
    .async_in (bus_enable),
    .sync_out (en_s)
  );

  always_comb begin
    pulse_c       = en_s & ~pg_reg;
    sync_bus_next = sync_bus_reg;
    if (pulse_c) begin
      sync_bus_next = unsync_bus;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pg_reg           <= 1'b0;
      sync_bus_reg     <= '0;
      enable_pulse_reg <= 1'b0;
    end else begin
      pg_reg           <= en_s;
      sync_bus_reg     <= sync_bus_next;
      enable_pulse_reg <= pulse_c;
    end
  end

  assign sync_bus     = sync_bus_reg;
  assign enable_pulse = enable_pulse_reg;

endmodule

// File: tb/tb_data_sync.sv
// Self-checking bench for data_sync: vector table plus scoreboard on the
// default instance, hand sequences for held level, reset and parameter sweep.
module tb_data_sync;

  typedef struct {
    logic [7:0] data;
    int         hold_cycles;
    int         low_cycles;
    int         exp_latency;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  bus0;
  logic        en0;
  logic [7:0]  sync_bus0;
  logic        pulse0;
  logic [31:0] bus1;
  logic        en1;
  logic [31:0] sync_bus1;
  logic        pulse1;
  logic [0:0]  bus2;
  logic        en2;
  logic [0:0]  sync_bus2;
  logic        pulse2;

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  logic [7:0]  exp_q[$];

  always #5 CLK = ~CLK;

  data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut0 (
    .CLK(CLK), .RST(RST), .unsync_bus(bus0), .bus_enable(en0),
    .sync_bus(sync_bus0), .enable_pulse(pulse0)
  );

  data_sync #(.BUS_WIDTH(32), .NUM_STAGES(1)) dut1 (
    .CLK(CLK), .RST(RST), .unsync_bus(bus1), .bus_enable(en1),
    .sync_bus(sync_bus1), .enable_pulse(pulse1)
  );

  data_sync #(.BUS_WIDTH(1), .NUM_STAGES(4)) dut2 (
    .CLK(CLK), .RST(RST), .unsync_bus(bus2), .bus_enable(en2),
    .sync_bus(sync_bus2), .enable_pulse(pulse2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Scoreboard: every pulse on the default instance must match the oldest expected capture.
  always @(negedge CLK) begin
    if (pulse0 === 1'b1) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got sync_bus=%h required no pulse", sync_bus0);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (sync_bus0 !== e) begin
          errors++;
          $display("FAIL capture: got sync_bus=%h required %h", sync_bus0, e);
        end else begin
          $display("xfer: sync_bus=%h expected=%h", sync_bus0, e);
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    int   cnt_before;
    int   cnt;

    vecs[0] = '{data: 8'hA5, hold_cycles: 10, low_cycles: 3, exp_latency: 3};
    vecs[1] = '{data: 8'h11, hold_cycles: 5,  low_cycles: 3, exp_latency: 3};
    vecs[2] = '{data: 8'h22, hold_cycles: 5,  low_cycles: 3, exp_latency: 3};
    vecs[3] = '{data: 8'h33, hold_cycles: 5,  low_cycles: 3, exp_latency: 3};
    vecs[4] = '{data: 8'hFF, hold_cycles: 4,  low_cycles: 3, exp_latency: 3};
    vecs[5] = '{data: 8'h00, hold_cycles: 4,  low_cycles: 5, exp_latency: 3};

    // Reset asserted with every input active: outputs must already be clear.
    RST  = 1'b0;
    en0  = 1'b1; bus0 = 8'hFF;
    en1  = 1'b1; bus1 = 32'hFFFF_FFFF;
    en2  = 1'b1; bus2 = 1'b1;
    #1;
    check("rst_bus0", {24'h0, sync_bus0}, 32'h0);
    check("rst_pulse0", {31'h0, pulse0}, 32'h0);
    check("rst_bus1", sync_bus1, 32'h0);
    check("rst_pulse1", {31'h0, pulse1}, 32'h0);
    check("rst_bus2", {31'h0, sync_bus2}, 32'h0);
    check("rst_pulse2", {31'h0, pulse2}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_bus0", {24'h0, sync_bus0}, 32'h0);
      check("rst_hold_pulse0", {31'h0, pulse0}, 32'h0);
    end
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    tick();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Table-driven transfers, including back-to-back with minimum low gap.
    for (int v = 0; v < 6; v++) begin
      bus0 = vecs[v].data;
      tick();
      en0 = 1'b1;
      exp_q.push_back(vecs[v].data);
      cnt_before = pulse_cnt;
      lat = -1;
      for (int i = 1; i <= vecs[v].hold_cycles; i++) begin
        tick();
        if (pulse0 === 1'b1 && lat < 0) lat = i;
      end
      en0 = 1'b0;
      for (int i = 0; i < vecs[v].low_cycles; i++) tick();
      check("vec_latency", lat, vecs[v].exp_latency);
      check("vec_pulse_count", pulse_cnt - cnt_before, 1);
    end

    // Held level with a bus change mid-way: one pulse, original data kept.
    bus0 = 8'hA5;
    tick();
    en0 = 1'b1;
    exp_q.push_back(8'hA5);
    cnt_before = pulse_cnt;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 20) bus0 = 8'h3C;
    end
    check("held_pulse_count", pulse_cnt - cnt_before, 1);
    check("held_sync_bus", {24'h0, sync_bus0}, 32'hA5);
    en0 = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Reset while the pulse is about to fire; fresh capture after release.
    bus0 = 8'h5A;
    tick();
    en0 = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
    check("midrst_bus0", {24'h0, sync_bus0}, 32'h0);
    check("midrst_pulse0", {31'h0, pulse0}, 32'h0);
    tick();
    tick();
    check("midrst_hold_bus0", {24'h0, sync_bus0}, 32'h0);
    check("midrst_hold_pulse0", {31'h0, pulse0}, 32'h0);
    RST = 1'b1;
    exp_q.push_back(8'h5A);
    cnt_before = pulse_cnt;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (pulse0 === 1'b1 && lat < 0) lat = i;
    end
    check("midrst_latency", lat, 3);
    check("midrst_pulse_count", pulse_cnt - cnt_before, 1);
    en0 = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // NUM_STAGES=1, 32-bit bus.
    bus1 = 32'hDEAD_BEEF;
    tick();
    en1 = 1'b1;
    lat = -1; cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (pulse1 === 1'b1) begin
        cnt++;
        if (lat < 0) lat = i;
      end
    end
    check("ns1_latency", lat, 2);
    check("ns1_pulse_count", cnt, 1);
    check("ns1_sync_bus", sync_bus1, 32'hDEAD_BEEF);
    en1 = 1'b0;
    $display("xfer: ns1 sync_bus=%h latency=%0d", sync_bus1, lat);

    // NUM_STAGES=4, 1-bit bus.
    bus2 = 1'b1;
    tick();
    en2 = 1'b1;
    lat = -1; cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pulse2 === 1'b1) begin
        cnt++;
        if (lat < 0) lat = i;
      end
    end
    check("ns4_latency", lat, 5);
    check("ns4_pulse_count", cnt, 1);
    check("ns4_sync_bus", {31'h0, sync_bus2}, 32'h1);
    en2 = 1'b0;
    $display("xfer: ns4 sync_bus=%h latency=%0d", sync_bus2, lat);

    for (int i = 0; i < 4; i++) tick();
    check("scoreboard_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
